// File: rtl/array_drain_pkg.sv
// Shared systolic-array definitions: default array geometry and drain FSM states.
// Used by the scheduler and by array_drain / drain_fifo.
package array_drain_pkg;

  localparam int DEFAULT_MATRIX_SIZE = 2;
  localparam int DEFAULT_DATA_SIZE   = 32;
  localparam int DEFAULT_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } drain_state_e;

  // Width of a row index able to hold 0..n (n = array dimension).
  function automatic int row_index_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/array_drain_fifo.sv
// drain_fifo: row buffer for array_drain. Power-of-two depth, wrapping pointers plus
// an occupancy count so full and empty are unambiguous. Read data is the head entry.
module drain_fifo
  import array_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full buffer is legal only when the head leaves at the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/array_drain.sv
// array_drain: de-skews the bottom PE row of the systolic array, buffers aligned result
// rows in drain_fifo and hands them out with ready/valid. Define ARRAY_DRAIN_RELU_EN for ReLU.
module array_drain
  import array_drain_pkg::*;
#(
  parameter int MATRIX_SIZE = DEFAULT_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [MATRIX_SIZE-1:0]           col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
  output logic [$clog2(MATRIX_SIZE):0]     out_row,
  output logic                             done,
  output logic                             overflow,
  output logic                             skew_err
);

  localparam int N  = MATRIX_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int RW = row_index_width(N);
  localparam int EW = N * DW + RW;

  logic [N-1:0]    dly_valid;
  logic [N*DW-1:0] dly_data;

  drain_state_e state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          overflow_q, overflow_d;
  logic          skew_q, skew_d;

  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;
  logic [RW-1:0] head_row;
  logic [N*DW-1:0] head_data;
  logic          all_v;
  logic          any_v;

  genvar gi;

  // Column j leaves the array j cycles after column 0, so it waits N-1-j stages.
  generate
    for (gi = 0; gi < N; gi++) begin : g_col
      localparam int STAGES = N - 1 - gi;
      if (STAGES == 0) begin : g_pass
        assign dly_valid[gi]         = col_valid[gi];
        assign dly_data[gi*DW +: DW] = col_data[gi*DW +: DW];
      end else begin : g_dly
        logic [STAGES-1:0] v_q;
        logic [DW-1:0]     d_q [STAGES];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
          end else begin
            v_q[0] <= col_valid[gi];
            d_q[0] <= col_data[gi*DW +: DW];
            for (int k = 1; k < STAGES; k++) begin
              v_q[k] <= v_q[k-1];
              d_q[k] <= d_q[k-1];
            end
          end
        end
        assign dly_valid[gi]         = v_q[STAGES-1];
        assign dly_data[gi*DW +: DW] = d_q[STAGES-1];
      end
    end
  endgenerate

  assign all_v = &dly_valid;
  assign any_v = |dly_valid;
  assign pop   = out_valid && out_ready;

  assign fifo_wdata            = {row_cnt_q, dly_data};
  assign {head_row, head_data} = fifo_rdata;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    skew_d     = skew_q;
    push       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = COLLECT;
          row_cnt_d  = '0;
          overflow_d = 1'b0;
          skew_d     = 1'b0;
        end
      end
      COLLECT: begin
        if (all_v) begin
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end else if (row_cnt_q != RW'(N)) begin
            push      = 1'b1;
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end else if (any_v) begin
          skew_d = 1'b1;
        end
        // Rows leave in order, so the matrix is finished when the last index is popped.
        if (pop && head_row == RW'(N - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      skew_q     <= skew_d;
    end
  end

  drain_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs read as zero whenever nothing is buffered; the clamp sits after the buffer.
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      logic [DW-1:0] word;
      assign word = head_data[gi*DW +: DW];
`ifdef ARRAY_DRAIN_RELU_EN
      assign out_data[gi*DW +: DW] = (fifo_empty || word[DW-1]) ? '0 : word;
`else
      assign out_data[gi*DW +: DW] = fifo_empty ? '0 : word;
`endif
    end
  endgenerate

  assign out_valid = !fifo_empty;
  assign out_row   = fifo_empty ? '0 : head_row;
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;
  assign skew_err  = skew_q;

endmodule

// File: tb/tb_array_drain.sv
// Self-checking bench for array_drain: a queue-level model drives a per-cycle compare on a
// 3x3 / depth-2 instance, plus directed literal checks on a default 2x2 instance.
module tb_array_drain;

  localparam int MN   = 3;
  localparam int DW   = 16;
  localparam int BD   = 2;
  localparam int MAXC = 8192;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance
  logic             start = 1'b0;
  logic [MN-1:0]    col_valid = '0;
  logic [MN*DW-1:0] col_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [MN*DW-1:0] out_data;
  logic [2:0]       out_row;
  logic             done, overflow, skew_err;

  // default-parameter instance
  logic        b_start = 1'b0;
  logic [1:0]  b_col_valid = '0;
  logic [63:0] b_col_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [63:0] b_out_data;
  logic [1:0]  b_out_row;
  logic        b_done, b_overflow, b_skew_err;

  array_drain #(.MATRIX_SIZE(MN), .DATA_SIZE(DW), .FIFO_DEPTH(BD)) u_dut (
    .clk(clk), .reset(reset), .start(start), .col_valid(col_valid), .col_data(col_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .done(done), .overflow(overflow), .skew_err(skew_err)
  );

  array_drain u_dut2 (
    .clk(clk), .reset(reset), .start(b_start), .col_valid(b_col_valid), .col_data(b_col_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_row(b_out_row),
    .done(b_done), .overflow(b_overflow), .skew_err(b_skew_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Rows indexed by the cycle in which their column 0 is presented.
  logic [MN-1:0] rv [MAXC];
  logic [DW-1:0] rdat [MAXC][MN];
  int cyc = 0;

  typedef struct {
    logic [MN*DW-1:0] data;
    int               row;
  } ent_t;

  ent_t mq[$];
  ent_t lg[$];
  int   mstate = M_IDLE;
  int   mcnt = 0;
  bit   mover = 1'b0;
  bit   mskew = 1'b0;

  function automatic logic [MN*DW-1:0] relu_row(input logic [MN*DW-1:0] x);
    logic [MN*DW-1:0] y;
    y = x;
`ifdef ARRAY_DRAIN_RELU_EN
    for (int j = 0; j < MN; j++) if (x[j*DW + DW - 1]) y[j*DW +: DW] = '0;
`endif
    return y;
  endfunction

  function automatic logic [MN*DW-1:0] pk(input logic [DW-1:0] d0, d1, d2);
    return {d2, d1, d0};
  endfunction

  // Reference model: a row is complete N-1 cycles after its column 0 appears.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      mstate = M_IDLE;
      mcnt = 0;
      mover = 1'b0;
      mskew = 1'b0;
    end else begin
      int   s;
      bit   pop, dopush;
      logic [MN-1:0] msk;
      ent_t e;
      s = cyc - (MN - 1);
      msk = (s >= 0) ? rv[s] : '0;
      pop = (mq.size() > 0) && out_ready;
      dopush = 1'b0;
      if (mstate == M_COLLECT) begin
        if (msk == {MN{1'b1}}) begin
          if (mq.size() == BD && !pop) mover = 1'b1;
          else if (mcnt < MN) begin
            for (int j = 0; j < MN; j++) e.data[j*DW +: DW] = rdat[s][j];
            e.row = mcnt;
            mcnt++;
            dopush = 1'b1;
          end
        end else if (msk != '0) mskew = 1'b1;
        if (pop && mq[0].row == MN - 1) mstate = M_DONE;
      end else if (start) begin
        mstate = M_COLLECT;
        mcnt = 0;
        mover = 1'b0;
        mskew = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (dopush) mq.push_back(e);
      cyc++;
    end
  end

  // Compare process: every cycle, away from the clock edge.
  initial forever begin
    @(negedge clk);
    if (chk_en && !reset) begin
      check("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("out_data", out_data, relu_row(mq[0].data));
        check("out_row", out_row, mq[0].row);
      end
      check("done", done, mstate == M_DONE);
      check("overflow", overflow, mover);
      check("skew_err", skew_err, mskew);
      if (out_valid && out_ready) begin
        ent_t e;
        e.data = out_data;
        e.row = out_row;
        lg.push_back(e);
        $display("pop row=%0d data=%h", out_row, out_data);
      end
    end
  end

  task automatic drv(input bit st, input bit rdy, input logic [MN-1:0] msk,
                     input logic [DW-1:0] d0, d1, d2);
    int idx;
    rv[cyc] = msk;
    rdat[cyc][0] = d0;
    rdat[cyc][1] = d1;
    rdat[cyc][2] = d2;
    start = st;
    out_ready = rdy;
    for (int j = 0; j < MN; j++) begin
      idx = cyc - j;
      col_valid[j]          = (idx >= 0) ? rv[idx][j] : 1'b0;
      col_data[j*DW +: DW]  = (idx >= 0) ? rdat[idx][j] : '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input bit rdy);
    for (int i = 0; i < k; i++) drv(1'b0, rdy, '0, '0, '0, '0);
  endtask

  task automatic b_drv(input bit st, input bit rdy, input logic [1:0] v,
                       input logic [31:0] d0, d1);
    b_start = st;
    b_out_ready = rdy;
    b_col_valid = v;
    b_col_data = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] neg3;
    for (int i = 0; i < MAXC; i++) begin
      rv[i] = '0;
      for (int j = 0; j < MN; j++) rdat[i][j] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, '0);
    check("rst out_row", out_row, '0);
    check("rst done", done, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst skew_err", skew_err, 1'b0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 2x2 alignment: {5,7} then {9,11}
    b_drv(1, 1, 2'b00, 0, 0);
    b_drv(0, 1, 2'b01, 5, 0);
    b_drv(0, 1, 2'b11, 9, 7);
    check("b row0 valid", b_out_valid, 1'b1);
    check("b row0 data", b_out_data, {32'd7, 32'd5});
    check("b row0 idx", b_out_row, 2'd0);
    b_drv(0, 1, 2'b10, 0, 11);
    check("b row1 data", b_out_data, {32'd11, 32'd9});
    check("b row1 idx", b_out_row, 2'd1);
    check("b done early", b_done, 1'b0);
    b_drv(0, 1, 2'b00, 0, 0);
    check("b done", b_done, 1'b1);
    check("b drained", b_out_valid, 1'b0);

    // ReLU on {-3,4}
    neg3 = -32'sd3;
    b_drv(1, 0, 2'b00, 0, 0);
    check("b done cleared", b_done, 1'b0);
    b_drv(0, 0, 2'b01, neg3, 0);
    b_drv(0, 0, 2'b10, 0, 4);
`ifdef ARRAY_DRAIN_RELU_EN
    check("b relu data", b_out_data, {32'd4, 32'd0});
`else
    check("b raw data", b_out_data, {32'd4, neg3});
`endif

    // Backpressure with depth 2: third row dropped
    lg.delete();
    drv(1, 0, '0, 0, 0, 0);
    drv(0, 0, '1, 5, 6, 7);
    drv(0, 0, '1, 8, 9, 10);
    drv(0, 0, '1, 11, 12, 13);
    idle(4, 0);
    check("bp overflow", overflow, 1'b1);
    check("bp held row", out_row, 3'd0);
    idle(4, 1);
    drv(0, 1, '1, 14, 15, 16);
    idle(5, 1);
    check("bp done", done, 1'b1);
    check("bp pops", lg.size(), 3);
    if (lg.size() == 3) begin
      check("bp row0", lg[0].data, pk(5, 6, 7));
      check("bp row1", lg[1].data, pk(8, 9, 10));
      check("bp row2", lg[2].data, pk(14, 15, 16));
      check("bp row2 idx", lg[2].row, 2);
    end

    // Full buffer with a pop on the edge the next row aligns
    lg.delete();
    drv(1, 0, '0, 0, 0, 0);
    drv(0, 0, '1, 1, 2, 3);
    drv(0, 0, '1, 4, 5, 6);
    idle(3, 0);
    drv(0, 0, '1, 7, 8, 9);
    drv(0, 0, '0, 0, 0, 0);
    drv(0, 1, '0, 0, 0, 0);
    idle(2, 0);
    check("fp overflow", overflow, 1'b0);
    check("fp head idx", out_row, 3'd1);
    idle(5, 1);
    check("fp done", done, 1'b1);
    check("fp pops", lg.size(), 3);
    if (lg.size() == 3) check("fp row2", lg[2].data, pk(7, 8, 9));

    // Skew, then reset with one row buffered
    drv(1, 0, '0, 0, 0, 0);
    drv(0, 0, 3'b001, 3, 0, 0);
    idle(4, 0);
    check("skew flag", skew_err, 1'b1);
    check("skew no push", out_valid, 1'b0);
    drv(0, 0, '1, 21, 22, 23);
    idle(4, 0);
    check("buffered", out_valid, 1'b1);
    reset = 1'b1;
    idle(1, 1);
    reset = 1'b0;
    idle(1, 1);
    check("post-reset empty", out_valid, 1'b0);
    check("post-reset skew", skew_err, 1'b0);
    idle(6, 1);
    check("still empty", out_valid, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [MN-1:0] msk;
      r = $urandom_range(0, 9);
      if (r < 4) msk = '0;
      else if (r < 9) msk = '1;
      else msk = MN'($urandom);
      drv(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), msk,
          DW'($urandom), DW'($urandom), DW'($urandom));
    end
    idle(10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
